sqrt_issue_scheduler: RTL and testbench

//  Shares one free-running, non-stallable square-root pipeline (all_arithm) between NREQ requesters.
//  A round-robin arbiter issues at most one operand per cycle. A tag shift register tracks each slot in flight.

---
 rtl/sqrt_issue_scheduler_pkg.sv | 22 ++
 rtl/sqrt_issue_scheduler_rr_arbiter.sv | 47 ++++
 rtl/sqrt_issue_scheduler.sv | 108 ++++++++++
 tb/tb_sqrt_issue_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_issue_scheduler_pkg.sv
// Shared types and constants for the square-root issue scheduler.
// Ids are stored at their widest size (up to 8 requesters) and narrowed at the top.
package sqrt_issue_scheduler_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned MAX_ID_W = 3;

   function automatic int unsigned id_w(input int unsigned nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

   typedef struct packed {
      logic [WORD_W-1:0]   data;
      logic [MAX_ID_W-1:0] id;
   } res_t;

endpackage

// File: rtl/sqrt_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at the rr pointer.
// The pointer moves past the winner only when a grant is actually issued.
module sqrt_issue_scheduler_rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic                    enable,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] idx
);

   localparam int unsigned ID_W = $clog2(NREQ);

   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] cand;
   logic            found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = ID_W'((32'(ptr_q) + k) % NREQ);
         if (enable && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (32'(idx) == NREQ - 1) ? '0 : idx + ID_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/sqrt_issue_scheduler.sv
// Shares one free-running square-root pipeline between NREQ requesters.
// Credits bound issued-but-unpopped results to FIFO_DEPTH, so FIFO writes are never qualified.
module sqrt_issue_scheduler
   import sqrt_issue_scheduler_pkg::*;
#(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned PIPE_LAT   = 5,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [WORD_W*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]          gnt,
   output logic [WORD_W-1:0]        ar_in_s,
   input  logic [WORD_W-1:0]        ar_sqrt,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WORD_W-1:0]        res_data,
   output logic [$clog2(NREQ)-1:0]  res_id,
   output logic                     busy
);

   localparam int unsigned ID_W  = $clog2(NREQ);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ID_W-1:0]   gnt_idx;
   logic              issue, push, pop, any_inflight;
   logic [WORD_W-1:0] sel_data;
   logic [CNT_W-1:0]  credits_q, occ_q;
   logic [PTR_W-1:0]  wptr_q, rptr_q;
   tag_t              tag_q [PIPE_LAT];
   res_t              mem_q [FIFO_DEPTH];
   res_t              head;

   // Reset gates the enable so no grant is seen while rst_n is low.
   sqrt_issue_scheduler_rr_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .enable(rst_n && (credits_q != '0)),
      .gnt   (gnt),
      .idx   (gnt_idx)
   );

   assign issue = |gnt;
   assign push  = tag_q[PIPE_LAT-1].valid;
   assign pop   = res_valid & res_ready;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (gnt[i]) sel_data = req_data[WORD_W*i +: WORD_W];
      end
      any_inflight = 1'b0;
      for (int s = 0; s < int'(PIPE_LAT); s++) begin
         any_inflight = any_inflight | tag_q[s].valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_in_s   <= '0;
         credits_q <= CNT_W'(FIFO_DEPTH);
         for (int s = 0; s < int'(PIPE_LAT); s++) tag_q[s] <= '0;
      end else begin
         if (issue) ar_in_s <= sel_data;
         tag_q[0] <= '{valid: issue, id: MAX_ID_W'(gnt_idx)};
         for (int s = 1; s < int'(PIPE_LAT); s++) tag_q[s] <= tag_q[s-1];
         case ({issue, pop})
            2'b10:   credits_q <= credits_q - CNT_W'(1);
            2'b01:   credits_q <= credits_q + CNT_W'(1);
            default: credits_q <= credits_q;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= '{data: ar_sqrt, id: tag_q[PIPE_LAT-1].id};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PTR_W'(1);
         if (pop)  rptr_q <= rptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   occ_q <= occ_q + CNT_W'(1);
            2'b01:   occ_q <= occ_q - CNT_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign head      = mem_q[rptr_q];
   assign res_valid = (occ_q != '0);
   assign res_data  = head.data;
   assign res_id    = ID_W'(head.id);
   assign busy      = any_inflight | res_valid;

endmodule

// File: tb/tb_sqrt_issue_scheduler.sv
// Directed and scoreboarded bench for sqrt_issue_scheduler with a behavioural all_arithm stand-in.
module tb_sqrt_issue_scheduler;

   localparam int NREQ = 4;
   localparam int PIPE_LAT = 5;
   localparam int FIFO_DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req = '0;
   logic [127:0] req_data = '0;
   logic [3:0]   gnt;
   logic [31:0]  ar_in_s, ar_sqrt, res_data;
   logic         res_valid, res_ready = 1'b0, busy;
   logic [1:0]   res_id;

   int vectors = 0;
   int miscompares = 0;
   int bp_n = 0;
   logic [31:0] bp_base = 32'h3F80_0000;

   always #5 clk = ~clk;

   sqrt_issue_scheduler #(
      .NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
      .ar_in_s(ar_in_s), .ar_sqrt(ar_sqrt), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .busy(busy)
   );

   // Exponent-halving sqrt, exact for even powers of two; result lands PIPE_LAT cycles after issue.
   function automatic logic [31:0] model_sqrt(input logic [31:0] x);
      logic [8:0] e;
      e = ({1'b0, x[30:23]} + 9'd127) >> 1;
      return {1'b0, e[7:0], x[22:0]};
   endfunction

   logic [31:0] arith_q [PIPE_LAT-1];
   always @(posedge clk) begin
      arith_q[0] <= model_sqrt(ar_in_s);
      for (int s = 1; s < PIPE_LAT - 1; s++) arith_q[s] <= arith_q[s-1];
   end
   assign ar_sqrt = arith_q[PIPE_LAT-2];

   function automatic logic [3:0] rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         int c = (p + k) % 4;
         if (r[c]) return 4'(1 << c);
      end
      return 4'b0000;
   endfunction

   function automatic logic [31:0] lane(input int i);
      return 32'h4180_0000 + 32'(i) * 32'h0080_0000;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req = '0; res_ready = 1'b0; req_data = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req = 4'b1111;
      req_data = {4{32'h4180_0000}};
      #2;
      vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (ar_in_s !== 32'h0) begin miscompares++; $display("FAIL reset_ar_in_s: got %h expected 00000000", ar_in_s); end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      @(negedge clk);
      req = 4'b0001; req_data[31:0] = 32'h4180_0000; #1;
      vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         req = '0; res_ready = (k == 6); #1;
         if (k == 1) begin
            vectors++; if (ar_in_s !== 32'h4180_0000) begin miscompares++; $display("FAIL single_ar_in_s: got %h expected 41800000", ar_in_s); end
         end
         vectors++; if (res_valid !== (k == 6)) begin miscompares++; $display("FAIL single_res_valid cycle %0d: got %b expected %b", k, res_valid, (k == 6)); end
         if (k == 6) begin
            vectors++; if (res_data !== 32'h4080_0000) begin miscompares++; $display("FAIL single_res_data: got %h expected 40800000", res_data); end
            vectors++; if (res_id !== 2'd0) begin miscompares++; $display("FAIL single_res_id: got %0d expected 0", res_id); end
         end
         if (k == 7) begin
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %b expected 0", busy); end
         end
      end
      res_ready = 1'b0;
   endtask

   task automatic test_fairness();
      int got = 0;
      logic [3:0] exp_g;
      do_reset();
      for (int i = 0; i < 4; i++) req_data[32*i +: 32] = lane(i);
      res_ready = 1'b1;
      for (int c = 0; c < 28; c++) begin
         @(negedge clk);
         req = (c < 8) ? 4'b1111 : 4'b0000; #1;
         exp_g = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
         vectors++; if (gnt !== exp_g) begin miscompares++; $display("FAIL fair_gnt cycle %0d: got %b expected %b", c, gnt, exp_g); end
         if (res_valid) begin
            vectors++; if (res_id !== 2'(got % 4) || res_data !== model_sqrt(lane(got % 4))) begin
               miscompares++; $display("FAIL fair_result %0d: got id %0d data %h expected id %0d data %h", got, res_id, res_data, got % 4, model_sqrt(lane(got % 4)));
            end
            got++;
         end
      end
      vectors++; if (got != 8) begin miscompares++; $display("FAIL fair_count: got %0d expected 8", got); end
      res_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [3:0] exp_g;
      do_reset();
      bp_n = 0;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         req = 4'b0100; req_data[64 +: 32] = bp_base + 32'(bp_n); res_ready = (c == 12); #1;
         exp_g = (c < 8 || c == 13) ? 4'b0100 : 4'b0000;
         vectors++; if (gnt !== exp_g) begin miscompares++; $display("FAIL bp_gnt cycle %0d: got %b expected %b", c, gnt, exp_g); end
         if (c == 12) begin
            vectors++; if (res_valid !== 1'b1 || res_data !== model_sqrt(bp_base)) begin
               miscompares++; $display("FAIL bp_pop: got valid %b data %h expected valid 1 data %h", res_valid, res_data, model_sqrt(bp_base));
            end
         end
         if (gnt[2]) bp_n++;
      end
      vectors++; if (bp_n != 9) begin miscompares++; $display("FAIL bp_grant_count: got %0d expected 9", bp_n); end
   endtask

   task automatic test_simultaneous();
      int k = 0;
      // Cycle 18: the operand granted at cycle 13 is written while the head is popped.
      @(negedge clk);
      req = 4'b0100; req_data[64 +: 32] = bp_base + 32'(bp_n); res_ready = 1'b1; #1;
      vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL sim_gnt_no_credit: got %b expected 0000", gnt); end
      vectors++; if (res_data !== model_sqrt(bp_base + 32'd1) || res_id !== 2'd2) begin
         miscompares++; $display("FAIL sim_pop: got %h id %0d expected %h id 2", res_data, res_id, model_sqrt(bp_base + 32'd1));
      end
      if (gnt[2]) bp_n++;
      @(negedge clk);
      res_ready = 1'b0; #1;
      vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL sim_gnt_credit_back: got %b expected 0100", gnt); end
      for (int c = 20; c < 50; c++) begin
         @(negedge clk);
         req = '0; res_ready = 1'b1; #1;
         if (res_valid) begin
            vectors++; if (res_data !== model_sqrt(bp_base + 32'(k + 2)) || res_id !== 2'd2) begin
               miscompares++; $display("FAIL sim_drain %0d: got %h id %0d expected %h id 2", k, res_data, res_id, model_sqrt(bp_base + 32'(k + 2)));
            end
            k++;
         end
      end
      vectors++; if (k != 8) begin miscompares++; $display("FAIL sim_drain_count: got %0d expected 8", k); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sim_busy_end: got %b expected 0", busy); end
      res_ready = 1'b0;
   endtask

   task automatic test_reset_midflight();
      int late = 0;
      do_reset();
      for (int i = 0; i < 4; i++) req_data[32*i +: 32] = lane(i);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req = 4'b0111; #1;
         vectors++; if (gnt !== 4'(1 << c)) begin miscompares++; $display("FAIL mid_gnt cycle %0d: got %b expected %b", c, gnt, 4'(1 << c)); end
      end
      @(negedge clk);
      rst_n = 1'b0; #1;
      vectors++; if ({gnt, res_valid, busy} !== 6'b0 || ar_in_s !== 32'h0) begin
         miscompares++; $display("FAIL mid_reset_outputs: got gnt %b valid %b busy %b ar_in_s %h expected all 0", gnt, res_valid, busy, ar_in_s);
      end
      @(negedge clk);
      rst_n = 1'b1; req = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (res_valid !== 1'b0 || busy !== 1'b0) late++;
      end
      vectors++; if (late != 0) begin miscompares++; $display("FAIL mid_after_release: got %0d cycles with valid/busy expected 0", late); end
   endtask

   task automatic test_random();
      logic [33:0] q[$];
      logic [33:0] front;
      logic [3:0]  r, exp_g;
      logic        rdy, pop;
      int          ptr = 0, outstanding = 0, id;
      do_reset();
      for (int c = 0; c < 4030; c++) begin
         @(negedge clk);
         if (c < 4000) begin
            r = 4'($urandom_range(0, 15));
            rdy = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 4; i++) req_data[32*i +: 32] = $urandom;
         end else begin
            r = 4'b0000; rdy = 1'b1;
         end
         req = r; res_ready = rdy; #1;
         exp_g = (outstanding < FIFO_DEPTH) ? rr_pick(r, ptr) : 4'b0000;
         vectors++; if (gnt !== exp_g) begin miscompares++; $display("FAIL rand_gnt cycle %0d: got %b expected %b", c, gnt, exp_g); end
         vectors++; if (busy !== (outstanding != 0)) begin miscompares++; $display("FAIL rand_busy cycle %0d: got %b expected %b", c, busy, (outstanding != 0)); end
         pop = res_valid && rdy;
         if (pop) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++; $display("FAIL rand_pop_empty cycle %0d: got data %h expected no result", c, res_data);
            end else begin
               front = q.pop_front();
               if ({res_data, res_id} !== front) begin
                  miscompares++; $display("FAIL rand_result cycle %0d: got %h/%0d expected %h/%0d", c, res_data, res_id, front[33:2], front[1:0]);
               end
            end
         end
         if (exp_g != 4'b0000) begin
            id = 0;
            for (int i = 0; i < 4; i++) if (exp_g[i]) id = i;
            q.push_back({model_sqrt(req_data[32*id +: 32]), 2'(id)});
            ptr = (id + 1) % 4;
         end
         outstanding = outstanding + ((exp_g != 4'b0000) ? 1 : 0) - (pop ? 1 : 0);
      end
      vectors++; if (q.size() != 0) begin miscompares++; $display("FAIL rand_leftover: got %0d undelivered expected 0", q.size()); end
      res_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_simultaneous();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
